br_resolve_unit: RTL and testbench

Branch resolution unit for the LC-3 datapath. It consumes the N/Z/P condition codes maintained by the PSR condition-code register and decides BR instructions. It waits out in-flight condition-code writes, evaluates the instruction's nzp mask against the condition codes, and issues a PC redirect plus flush to fetch on a taken branch. It sits between decode (which hands over BR instructions) and the fetch PC mux, alongside the execute-stage condition-code writer.

---
 rtl/br_resolve_unit.sv | 136 +++++++++++++
 tb/tb_br_resolve_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: LC-3 branch resolution.
// Accepts BR instructions from decode. It waits until no condition-code write is in flight,
// then evaluates the nzp mask against psr. On a taken branch it holds a redirect with flush
// to fetch until fetch accepts it.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   br_valid/br_ready/br_ir/br_pc  branch handoff from decode
//   psr, cc_pending, cc_write      condition codes and in-flight CC write status
//   resolve_valid/taken/err        one-cycle decision pulse
//   redirect_valid/ready/pc, flush fetch redirect handshake
//   taken_count, branch_count      wrapping statistics counters
module br_resolve_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [15:0] br_ir,
    input  logic [15:0] br_pc,
    input  logic [2:0]  psr,
    input  logic        cc_pending,
    input  logic        cc_write,
    output logic        resolve_valid,
    output logic        resolve_taken,
    output logic        resolve_err,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic [15:0] taken_count,
    output logic [15:0] branch_count
);

    typedef enum logic [1:0] {StIdle, StWaitCc, StEval, StRedirect} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_ir, w_ir_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_redirect_pc, w_redirect_pc_nxt;
    logic [15:0] r_taken_count, w_taken_count_nxt;
    logic [15:0] r_branch_count, w_branch_count_nxt;
    logic        r_resolve_valid, w_resolve_valid_nxt;
    logic        r_resolve_taken, w_resolve_taken_nxt;
    logic        r_resolve_err, w_resolve_err_nxt;

    logic        w_err;
    logic [2:0]  w_nzp;
    logic        w_taken;
    logic [15:0] w_target;

    assign w_err    = (r_ir[15:12] != 4'h0);
    assign w_nzp    = r_ir[11:9];
    // A malformed opcode is reported but never redirects fetch.
    assign w_taken  = !w_err && ((w_nzp == 3'b111) || ((w_nzp & psr) != 3'b000));
    assign w_target = r_pc + 16'd1 + {{7{r_ir[8]}}, r_ir[8:0]};

    always_comb begin
        w_state_nxt         = r_state;
        w_ir_nxt            = r_ir;
        w_pc_nxt            = r_pc;
        w_redirect_pc_nxt   = r_redirect_pc;
        w_taken_count_nxt   = r_taken_count;
        w_branch_count_nxt  = r_branch_count;
        w_resolve_valid_nxt = 1'b0;
        w_resolve_taken_nxt = 1'b0;
        w_resolve_err_nxt   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (br_valid) begin
                    w_ir_nxt    = br_ir;
                    w_pc_nxt    = br_pc;
                    w_state_nxt = (cc_pending || cc_write) ? StWaitCc : StEval;
                end
            end
            StWaitCc: begin
                // psr is only trusted once no CC write is pending or landing this cycle.
                if (!cc_pending && !cc_write) begin
                    w_state_nxt = StEval;
                end
            end
            StEval: begin
                w_resolve_valid_nxt = 1'b1;
                w_resolve_taken_nxt = w_taken;
                w_resolve_err_nxt   = w_err;
                w_branch_count_nxt  = r_branch_count + 16'd1;
                if (w_taken) begin
                    w_taken_count_nxt = r_taken_count + 16'd1;
                    w_redirect_pc_nxt = w_target;
                    w_state_nxt       = StRedirect;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StRedirect: begin
                if (redirect_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_ir            <= 16'h0000;
            r_pc            <= 16'h0000;
            r_redirect_pc   <= 16'h0000;
            r_taken_count   <= 16'h0000;
            r_branch_count  <= 16'h0000;
            r_resolve_valid <= 1'b0;
            r_resolve_taken <= 1'b0;
            r_resolve_err   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ir            <= w_ir_nxt;
            r_pc            <= w_pc_nxt;
            r_redirect_pc   <= w_redirect_pc_nxt;
            r_taken_count   <= w_taken_count_nxt;
            r_branch_count  <= w_branch_count_nxt;
            r_resolve_valid <= w_resolve_valid_nxt;
            r_resolve_taken <= w_resolve_taken_nxt;
            r_resolve_err   <= w_resolve_err_nxt;
        end
    end

    assign br_ready       = (r_state == StIdle);
    assign redirect_valid = (r_state == StRedirect);
    assign flush          = (r_state == StRedirect);
    assign redirect_pc    = r_redirect_pc;
    assign resolve_valid  = r_resolve_valid;
    assign resolve_taken  = r_resolve_taken;
    assign resolve_err    = r_resolve_err;
    assign taken_count    = r_taken_count;
    assign branch_count   = r_branch_count;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Self-checking bench for br_resolve_unit: per-scenario tasks with a scoreboard of expected
// branch outcomes, pushed at issue and popped when resolve_valid appears.
module tb_br_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, br_valid, br_ready, cc_pending, cc_write;
    logic [15:0] br_ir, br_pc, redirect_pc, taken_count, branch_count;
    logic [2:0]  psr;
    logic        resolve_valid, resolve_taken, resolve_err;
    logic        redirect_valid, redirect_ready, flush;

    always #5 clk = ~clk;

    br_resolve_unit dut (
        .clk           (clk),
        .rst           (rst),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_ir         (br_ir),
        .br_pc         (br_pc),
        .psr           (psr),
        .cc_pending    (cc_pending),
        .cc_write      (cc_write),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_err   (resolve_err),
        .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .taken_count   (taken_count),
        .branch_count  (branch_count)
    );

    typedef struct packed {
        logic        taken;
        logic        err;
        logic [15:0] target;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          n;
    logic [15:0] exp_br = 16'h0000;
    logic [15:0] exp_tk = 16'h0000;

    function automatic exp_t model(input logic [15:0] ir, input logic [15:0] pc,
                                   input logic [2:0] cc);
        exp_t     r;
        logic [2:0] m;
        int       off;
        m     = ir[11:9];
        r.err = (ir[15:12] != 4'h0);
        r.taken = !r.err && ((m == 3'b111) || ((m & cc) != 3'b000));
        off   = ir[8] ? int'(ir[8:0]) - 512 : int'(ir[8:0]);
        r.target = 16'(int'(pc) + 1 + off);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one branch for the capture edge; cc_eval is the psr the unit should evaluate.
    task automatic issue(input logic [15:0] ir, input logic [15:0] pc,
                         input logic [2:0] cc_drive, input logic [2:0] cc_eval);
        br_valid = 1'b1;
        br_ir    = ir;
        br_pc    = pc;
        psr      = cc_drive;
        sb.push_back(model(ir, pc, cc_eval));
        tick();
        br_valid = 1'b0;
    endtask

    task automatic wait_resolve(output int cnt);
        cnt = 0;
        while (resolve_valid !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset_init();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({br_ready, resolve_valid, resolve_taken, resolve_err, redirect_valid, flush}
            !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 100000",
                     {br_ready, resolve_valid, resolve_taken, resolve_err, redirect_valid, flush});
        end
        total++;
        if (redirect_pc !== 16'h0000) begin
            bad++;
            $display("FAIL reset_pc: got %h want 0000", redirect_pc);
        end
        total++;
        if ({branch_count, taken_count} !== 32'h0) begin
            bad++;
            $display("FAIL reset_counts: got %h/%h want 0000/0000", branch_count, taken_count);
        end
    endtask

    task automatic test_not_taken();
        redirect_ready = 1'b1;
        issue(16'h0805, 16'h3000, 3'b001, 3'b001);
        total++;
        if (resolve_valid !== 1'b0) begin
            bad++;
            $display("FAIL nt_early: resolve_valid got %b want 0 in EVAL", resolve_valid);
        end
        wait_resolve(n);
        e = sb.pop_front();
        exp_br++;
        if (e.taken) exp_tk++;
        total++;
        if (resolve_valid !== 1'b1 || n != 1) begin
            bad++;
            $display("FAIL nt_latency: got valid=%b after %0d want valid=1 after 1",
                     resolve_valid, n);
        end
        total++;
        if ({resolve_taken, resolve_err, redirect_valid, br_ready} !== {e.taken, e.err, 2'b01}) begin
            bad++;
            $display("FAIL nt_outcome: got %b want %b",
                     {resolve_taken, resolve_err, redirect_valid, br_ready},
                     {e.taken, e.err, 2'b01});
        end
        total++;
        if ({branch_count, taken_count} !== {exp_br, exp_tk}) begin
            bad++;
            $display("FAIL nt_counts: got %h/%h want %h/%h", branch_count, taken_count,
                     exp_br, exp_tk);
        end
        tick();
    endtask

    task automatic test_taken_backpressure();
        redirect_ready = 1'b0;
        issue(16'h05FE, 16'h3010, 3'b010, 3'b010);
        wait_resolve(n);
        e = sb.pop_front();
        exp_br++;
        if (e.taken) exp_tk++;
        total++;
        if (resolve_valid !== 1'b1 || n != 1 || resolve_taken !== e.taken) begin
            bad++;
            $display("FAIL bp_resolve: got valid=%b taken=%b after %0d want 1/%b after 1",
                     resolve_valid, resolve_taken, n, e.taken);
        end
        total++;
        if ({branch_count, taken_count} !== {exp_br, exp_tk}) begin
            bad++;
            $display("FAIL bp_counts: got %h/%h want %h/%h", branch_count, taken_count,
                     exp_br, exp_tk);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== e.target ||
                br_ready !== 1'b0 || (i > 0 && resolve_valid !== 1'b0)) begin
                bad++;
                $display("FAIL bp_hold%0d: got rv=%b fl=%b pc=%h rdy=%b res=%b want 1/1/%h/0",
                         i, redirect_valid, flush, redirect_pc, br_ready, resolve_valid,
                         e.target);
            end
            if (i == 3) redirect_ready = 1'b1;
            tick();
        end
        total++;
        if ({br_ready, redirect_valid, flush} !== 3'b100 || redirect_pc !== e.target) begin
            bad++;
            $display("FAIL bp_release: got rdy/rv/fl=%b pc=%h want 100 pc=%h",
                     {br_ready, redirect_valid, flush}, redirect_pc, e.target);
        end
    endtask

    task automatic test_cc_hazard();
        redirect_ready = 1'b1;
        cc_pending     = 1'b1;
        issue(16'h0204, 16'h3020, 3'b100, 3'b001);
        tick();
        cc_write = 1'b1;
        total++;
        if (resolve_valid !== 1'b0) begin
            bad++;
            $display("FAIL cc_early: resolve_valid got %b want 0", resolve_valid);
        end
        tick();
        cc_write   = 1'b0;
        cc_pending = 1'b0;
        psr        = 3'b001;
        wait_resolve(n);
        e = sb.pop_front();
        exp_br++;
        if (e.taken) exp_tk++;
        total++;
        if (resolve_valid !== 1'b1 || n != 2) begin
            bad++;
            $display("FAIL cc_latency: got valid=%b after %0d want valid=1 after 2",
                     resolve_valid, n);
        end
        total++;
        if (resolve_taken !== e.taken || redirect_valid !== e.taken ||
            redirect_pc !== e.target) begin
            bad++;
            $display("FAIL cc_outcome: got taken=%b rv=%b pc=%h want %b/%b/%h",
                     resolve_taken, redirect_valid, redirect_pc, e.taken, e.taken, e.target);
        end
        tick();
    endtask

    logic [15:0] em_ir[3];
    logic [2:0]  em_cc[3];

    task automatic test_edge_masks();
        em_ir[0] = 16'h0E00; em_cc[0] = 3'b000;
        em_ir[1] = 16'h0005; em_cc[1] = 3'b111;
        em_ir[2] = 16'h1E00; em_cc[2] = 3'b111;
        redirect_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(em_ir[i], 16'h4000, em_cc[i], em_cc[i]);
            wait_resolve(n);
            e = sb.pop_front();
            exp_br++;
            if (e.taken) exp_tk++;
            total++;
            if (resolve_valid !== 1'b1 || {resolve_taken, resolve_err} !== {e.taken, e.err} ||
                redirect_valid !== e.taken) begin
                bad++;
                $display("FAIL mask%0d: got v=%b t=%b e=%b rv=%b want 1/%b/%b/%b", i,
                         resolve_valid, resolve_taken, resolve_err, redirect_valid,
                         e.taken, e.err, e.taken);
            end
            total++;
            if ({branch_count, taken_count} !== {exp_br, exp_tk}) begin
                bad++;
                $display("FAIL mask%0d_counts: got %h/%h want %h/%h", i, branch_count,
                         taken_count, exp_br, exp_tk);
            end
            tick();
            total++;
            if (resolve_valid !== 1'b0 || resolve_err !== 1'b0) begin
                bad++;
                $display("FAIL mask%0d_pulse: got v=%b e=%b want 0/0", i, resolve_valid,
                         resolve_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ir;
        logic [2:0]  cc;
        redirect_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ir = {4'h0, 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511))};
            cc = 3'($urandom_range(0, 7));
            issue(ir, 16'($urandom_range(0, 65535)), cc, cc);
            wait_resolve(n);
            e = sb.pop_front();
            exp_br++;
            if (e.taken) exp_tk++;
            total++;
            if (resolve_valid !== 1'b1 || n != 1 || resolve_taken !== e.taken ||
                br_ready !== !e.taken || (e.taken && redirect_pc !== e.target)) begin
                bad++;
                $display("FAIL b2b%0d: got v=%b n=%0d t=%b rdy=%b pc=%h want 1/1/%b/%b/%h", k,
                         resolve_valid, n, resolve_taken, br_ready, redirect_pc, e.taken,
                         !e.taken, e.target);
            end
            total++;
            if ({branch_count, taken_count} !== {exp_br, exp_tk}) begin
                bad++;
                $display("FAIL b2b%0d_counts: got %h/%h want %h/%h", k, branch_count,
                         taken_count, exp_br, exp_tk);
            end
            // Not-taken branches are followed by a new issue in the very same cycle.
            if (e.taken) tick();
        end
    endtask

    task automatic test_wrap();
        redirect_ready = 1'b1;
        issue(16'h0E00, 16'hFFFF, 3'b000, 3'b000);
        wait_resolve(n);
        e = sb.pop_front();
        exp_br++;
        if (e.taken) exp_tk++;
        total++;
        if (resolve_valid !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_pc: got v=%b rv=%b pc=%h want 1/1/0000", resolve_valid,
                     redirect_valid, redirect_pc);
        end
        tick();
        // Preload the taken counter instead of issuing 65535 branches.
        force dut.r_taken_count = 16'hFFFF;
        tick();
        release dut.r_taken_count;
        exp_tk = 16'hFFFF;
        tick();
        total++;
        if (taken_count !== exp_tk) begin
            bad++;
            $display("FAIL wrap_preload: got %h want %h", taken_count, exp_tk);
        end
        issue(16'h0E00, 16'h5000, 3'b000, 3'b000);
        wait_resolve(n);
        e = sb.pop_front();
        exp_br++;
        if (e.taken) exp_tk++;
        total++;
        if (resolve_valid !== 1'b1 || taken_count !== 16'h0000 || branch_count !== exp_br) begin
            bad++;
            $display("FAIL wrap_count: got v=%b tk=%h br=%h want 1/0000/%h", resolve_valid,
                     taken_count, branch_count, exp_br);
        end
        tick();
    endtask

    task automatic test_reset_mid_redirect();
        redirect_ready = 1'b0;
        issue(16'h05FE, 16'h3010, 3'b010, 3'b010);
        wait_resolve(n);
        e = sb.pop_front();
        tick();
        total++;
        if (redirect_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstr_setup: redirect_valid got %b want 1", redirect_valid);
        end
        rst = 1'b1;
        tick();
        exp_br = 16'h0000;
        exp_tk = 16'h0000;
        total++;
        if ({br_ready, redirect_valid, flush, resolve_valid} !== 4'b1000 ||
            redirect_pc !== 16'h0000 || {branch_count, taken_count} !== {exp_br, exp_tk}) begin
            bad++;
            $display("FAIL rstr_first: got flags=%b pc=%h cnt=%h/%h want 1000 0000 0000/0000",
                     {br_ready, redirect_valid, flush, resolve_valid}, redirect_pc,
                     branch_count, taken_count);
        end
        tick();
        rst = 1'b0;
        redirect_ready = 1'b1;
        tick();
        total++;
        if ({br_ready, redirect_valid, flush} !== 3'b100 ||
            {branch_count, taken_count} !== {exp_br, exp_tk}) begin
            bad++;
            $display("FAIL rstr_after: got flags=%b cnt=%h/%h want 100 0000/0000",
                     {br_ready, redirect_valid, flush}, branch_count, taken_count);
        end
    endtask

    initial begin
        rst            = 1'b1;
        br_valid       = 1'b0;
        br_ir          = 16'h0000;
        br_pc          = 16'h0000;
        psr            = 3'b000;
        cc_pending     = 1'b0;
        cc_write       = 1'b0;
        redirect_ready = 1'b0;
        test_reset_init();
        test_not_taken();
        test_taken_backpressure();
        test_cc_hazard();
        test_edge_masks();
        test_back_to_back();
        test_wrap();
        test_reset_mid_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
